// File: rtl/hamming_secded_stream_if.sv
// -----------------------------------------------------------------------------
// hamming_secded_stream_if
// Purpose : bundles the stream handshake, payload/codeword buses, status
//           outputs, counter controls and error-injection controls of the
//           extended-Hamming SECDED block.
// Modports:
//   master - producer/consumer side (drives in_*, out_ready, cnt_clr, inj_*)
//   slave  - the SECDED block (drives in_ready, out_*, corr_cnt, uncorr_cnt)
// Parameters DATA_W / CNT_W must match those given to the block.
// -----------------------------------------------------------------------------
interface hamming_secded_stream_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  // Smallest r with 2^r >= DATA_W + r + 1.
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    for (int k = 0; k < 32; k++) begin
      r = ((1 << r) < (dw + r + 1)) ? (r + 1) : r;
    end
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;
  localparam int POS_W  = $clog2(CODE_W);

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [DATA_W-1:0] in_data;
  logic [CODE_W-1:0] in_code;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [DATA_W-1:0] out_data;
  logic              out_single_err;
  logic              out_double_err;
  logic [PAR_W-1:0]  out_syndrome;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;
  logic              cnt_clr;
  logic              inj_en;
  logic [POS_W-1:0]  inj_pos;

  modport master (
    output in_valid, in_mode, in_data, in_code, out_ready, cnt_clr, inj_en, inj_pos,
    input  in_ready, out_valid, out_code, out_data, out_single_err, out_double_err,
           out_syndrome, corr_cnt, uncorr_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_code, out_ready, cnt_clr, inj_en, inj_pos,
    output in_ready, out_valid, out_code, out_data, out_single_err, out_double_err,
           out_syndrome, corr_cnt, uncorr_cnt
  );
endinterface

// File: rtl/hamming_secded_stream.sv
// -----------------------------------------------------------------------------
// hamming_secded_stream
// Purpose : parametrised extended-Hamming SECDED encoder/decoder on a
//           valid/ready stream with a per-beat mode bit (0=encode, 1=decode)
//           and one registered output stage. Decode corrects single errors,
//           flags double errors and keeps saturating error counters.
// Ports   : clk, rst (synchronous, active high)
//           bus (hamming_secded_stream_if.slave): in_valid/in_ready/in_mode/
//           in_data/in_code, out_valid/out_ready/out_code/out_data/
//           out_single_err/out_double_err/out_syndrome, corr_cnt/uncorr_cnt/
//           cnt_clr, inj_en/inj_pos.
// Codeword: code[0] overall even parity, code[1..N] Hamming positions,
//           parity at powers of two, data[0] at position 3 ascending.
// Option  : define HAMMING_ERR_INJECT_EN to flip bit inj_pos of the encoded
//           word on encode beats accepted with inj_en=1.
// -----------------------------------------------------------------------------
module hamming_secded_stream #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  hamming_secded_stream_if.slave bus
);
  // Smallest r with 2^r >= DATA_W + r + 1.
  function automatic int calc_par_w(input int dw);
    int r;
    r = 1;
    for (int k = 0; k < 32; k++) begin
      r = ((1 << r) < (dw + r + 1)) ? (r + 1) : r;
    end
    return r;
  endfunction

  localparam int PAR_W  = calc_par_w(DATA_W);
  localparam int N      = DATA_W + PAR_W;
  localparam int CODE_W = N + 1;

  function automatic logic is_pow2(input int p);
    return ((p & (p - 1)) == 0);
  endfunction

  // Build the full codeword: scatter data, then per-bit parity, then overall.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              p;
    int                di;
    c  = {CODE_W{1'b0}};
    di = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) begin
        c[pos] = d[di];
        di     = di + 1;
      end
    end
    for (int k = 0; k < PAR_W; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= N; pos++) begin
        if (pos[k] && !is_pow2(pos)) begin
          p = p ^ c[pos];
        end
      end
      c[1 << k] = p;
    end
    c[0] = ^c[N:1];
    return c;
  endfunction

  // XOR of the positions of all set bits in code[N:1].
  function automatic logic [PAR_W-1:0] syndrome_of(input logic [CODE_W-1:0] c);
    logic [PAR_W-1:0] s;
    s = {PAR_W{1'b0}};
    for (int pos = 1; pos <= N; pos++) begin
      if (c[pos]) begin
        s = s ^ PAR_W'(pos);
      end
    end
    return s;
  endfunction

  // Gather payload bits from the non-power-of-two positions.
  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int                di;
    d  = {DATA_W{1'b0}};
    di = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if (!is_pow2(pos)) begin
        d[di] = c[pos];
        di    = di + 1;
      end
    end
    return d;
  endfunction

  logic              r_out_valid;
  logic [CODE_W-1:0] r_out_code;
  logic [DATA_W-1:0] r_out_data;
  logic              r_single;
  logic              r_double;
  logic [PAR_W-1:0]  r_syndrome;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic [CODE_W-1:0] w_enc;
  logic [CODE_W-1:0] w_inj_mask;
  logic [PAR_W-1:0]  w_syn;
  logic              w_ovr;
  logic [CODE_W-1:0] w_fix;
  logic              w_single;
  logic              w_double;
  logic [DATA_W-1:0] w_dec_data;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

`ifdef HAMMING_ERR_INJECT_EN
  // Out-of-range positions inject nothing.
  assign w_inj_mask = (bus.inj_en && (32'(bus.inj_pos) < CODE_W))
                    ? (CODE_W'(1) << bus.inj_pos) : {CODE_W{1'b0}};
`else
  logic w_unused_inj;
  assign w_inj_mask   = {CODE_W{1'b0}};
  assign w_unused_inj = ^{bus.inj_en, bus.inj_pos};
`endif

  // Encode path and SECDED classification/correction of the incoming word.
  always_comb begin
    w_enc    = encode(bus.in_data);
    w_syn    = syndrome_of(bus.in_code);
    w_ovr    = ^bus.in_code;
    w_fix    = bus.in_code;
    w_single = 1'b0;
    w_double = 1'b0;
    if (w_ovr) begin
      if (w_syn == {PAR_W{1'b0}}) begin
        w_single = 1'b1;
      end else if (32'(w_syn) <= N) begin
        w_single       = 1'b1;
        w_fix[w_syn]   = ~bus.in_code[w_syn];
      end else begin
        // Syndrome points past the last position: cannot be a single error.
        w_double = 1'b1;
      end
    end else begin
      if (w_syn != {PAR_W{1'b0}}) begin
        w_double = 1'b1;
      end else begin
        w_double = 1'b0;
      end
    end
    w_dec_data = extract(w_fix);
  end

  // Output stage: load on accept, drop valid after a pop with no push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_code  <= {CODE_W{1'b0}};
      r_out_data  <= {DATA_W{1'b0}};
      r_single    <= 1'b0;
      r_double    <= 1'b0;
      r_syndrome  <= {PAR_W{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      if (bus.in_mode) begin
        r_out_code <= {CODE_W{1'b0}};
        r_out_data <= w_dec_data;
        r_single   <= w_single;
        r_double   <= w_double;
        r_syndrome <= w_syn;
      end else begin
        r_out_code <= w_enc ^ w_inj_mask;
        r_out_data <= {DATA_W{1'b0}};
        r_single   <= 1'b0;
        r_double   <= 1'b0;
        r_syndrome <= {PAR_W{1'b0}};
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr) begin
      r_corr_cnt   <= {CNT_W{1'b0}};
      r_uncorr_cnt <= {CNT_W{1'b0}};
    end else if (w_accept && bus.in_mode) begin
      if (w_single && (r_corr_cnt != {CNT_W{1'b1}})) begin
        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      end
      if (w_double && (r_uncorr_cnt != {CNT_W{1'b1}})) begin
        r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_code       = r_out_code;
  assign bus.out_data       = r_out_data;
  assign bus.out_single_err = r_single;
  assign bus.out_double_err = r_double;
  assign bus.out_syndrome   = r_syndrome;
  assign bus.corr_cnt       = r_corr_cnt;
  assign bus.uncorr_cnt     = r_uncorr_cnt;
endmodule

// File: tb/tb_hamming_secded_stream.sv
// -----------------------------------------------------------------------------
// tb_hamming_secded_stream
// Directed, self-checking bench for hamming_secded_stream at DATA_W=4, CNT_W=2
// (CODE_W=8). Expected codewords are hand-computed from the codeword layout.
// -----------------------------------------------------------------------------
module tb_hamming_secded_stream;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  hamming_secded_stream_if #(.DATA_W(4), .CNT_W(2)) bus_if ();

  hamming_secded_stream #(.DATA_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enc(input logic [3:0] d);
    bus_if.in_valid = 1'b1;
    bus_if.in_mode  = 1'b0;
    bus_if.in_data  = d;
  endtask

  task automatic dec(input logic [7:0] c);
    bus_if.in_valid = 1'b1;
    bus_if.in_mode  = 1'b1;
    bus_if.in_code  = c;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_mode   = 1'b0;
    bus_if.in_data   = 4'h0;
    bus_if.in_code   = 8'h00;
    bus_if.out_ready = 1'b1;
    bus_if.cnt_clr   = 1'b0;
    bus_if.inj_en    = 1'b0;
    bus_if.inj_pos   = 3'd0;
    tick();
    tick();
    chk("rst_valid", 32'(bus_if.out_valid), 32'h0);
    chk("rst_code", 32'(bus_if.out_code), 32'h0);
    chk("rst_data", 32'(bus_if.out_data), 32'h0);
    chk("rst_flags", 32'({bus_if.out_single_err, bus_if.out_double_err, bus_if.out_syndrome}), 32'h0);
    chk("rst_cnts", 32'({bus_if.corr_cnt, bus_if.uncorr_cnt}), 32'h0);

    rst = 1'b0;
    bus_if.out_ready = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bus_if.in_ready), 32'h1);
    bus_if.out_ready = 1'b1;

    // Encode 1011 -> AA
    enc(4'b1011);
    tick();
    chk("enc_valid", 32'(bus_if.out_valid), 32'h1);
    chk("enc_code", 32'(bus_if.out_code), 32'hAA);
    chk("enc_flags", 32'({bus_if.out_single_err, bus_if.out_double_err, bus_if.out_syndrome}), 32'h0);
    chk("enc_data", 32'(bus_if.out_data), 32'h0);

    // Bit 5 flipped
    dec(8'h8A);
    tick();
    chk("s5_data", 32'(bus_if.out_data), 32'hB);
    chk("s5_flags", 32'({bus_if.out_single_err, bus_if.out_double_err}), 32'h2);
    chk("s5_syn", 32'(bus_if.out_syndrome), 32'h5);
    chk("s5_corr", 32'(bus_if.corr_cnt), 32'h1);
    chk("s5_code", 32'(bus_if.out_code), 32'h0);

    // Overall parity bit flipped
    dec(8'hAB);
    tick();
    chk("ov_data", 32'(bus_if.out_data), 32'hB);
    chk("ov_flags", 32'({bus_if.out_single_err, bus_if.out_double_err}), 32'h2);
    chk("ov_syn", 32'(bus_if.out_syndrome), 32'h0);
    chk("ov_corr", 32'(bus_if.corr_cnt), 32'h2);

    // Bits 5 and 6 flipped: syndrome 3, uncorrected data 1101
    dec(8'hCA);
    tick();
    chk("dbl_flags", 32'({bus_if.out_single_err, bus_if.out_double_err}), 32'h1);
    chk("dbl_data", 32'(bus_if.out_data), 32'hD);
    chk("dbl_syn", 32'(bus_if.out_syndrome), 32'h3);
    chk("dbl_uncorr", 32'(bus_if.uncorr_cnt), 32'h1);
    chk("dbl_corr", 32'(bus_if.corr_cnt), 32'h2);

    // Clean word
    dec(8'hAA);
    tick();
    chk("clean_flags", 32'({bus_if.out_single_err, bus_if.out_double_err, bus_if.out_syndrome}), 32'h0);
    chk("clean_data", 32'(bus_if.out_data), 32'hB);
    chk("clean_cnts", 32'({bus_if.corr_cnt, bus_if.uncorr_cnt}), 32'h9);

    // Pop with no push
    bus_if.in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(bus_if.out_valid), 32'h0);

    // Backpressure: 0001->0F held, then 0010->33, 0100->55
    bus_if.out_ready = 1'b0;
    enc(4'b0001);
    tick();
    chk("bp_code0", 32'(bus_if.out_code), 32'h0F);
    chk("bp_ready0", 32'(bus_if.in_ready), 32'h0);
    enc(4'b0010);
    tick();
    chk("bp_hold1", 32'({bus_if.out_valid, bus_if.out_code}), 32'h10F);
    chk("bp_ready1", 32'(bus_if.in_ready), 32'h0);
    tick();
    chk("bp_hold2", 32'({bus_if.out_valid, bus_if.out_code}), 32'h10F);
    bus_if.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus_if.in_ready), 32'h1);
    tick();
    chk("bp_code1", 32'({bus_if.out_valid, bus_if.out_code}), 32'h133);
    enc(4'b0100);
    tick();
    chk("bp_code2", 32'({bus_if.out_valid, bus_if.out_code}), 32'h155);
    bus_if.in_valid = 1'b0;
    tick();
    chk("bp_drain", 32'(bus_if.out_valid), 32'h0);

    // Saturation: three more corrected beats (5 total) -> 3
    dec(8'h8A);
    tick();
    chk("sat_3", 32'(bus_if.corr_cnt), 32'h3);
    tick();
    tick();
    chk("sat_hold", 32'(bus_if.corr_cnt), 32'h3);

    // Clear coincident with a 6th corrected beat
    bus_if.cnt_clr = 1'b1;
    tick();
    bus_if.cnt_clr = 1'b0;
    chk("clr_cnts", 32'({bus_if.corr_cnt, bus_if.uncorr_cnt}), 32'h0);
    chk("clr_beat_single", 32'(bus_if.out_single_err), 32'h1);

    // Injection on encode, none on decode
    bus_if.inj_en  = 1'b1;
    bus_if.inj_pos = 3'd2;
    enc(4'b1011);
    tick();
`ifdef HAMMING_ERR_INJECT_EN
    chk("inj_code", 32'(bus_if.out_code), 32'hAE);
`else
    chk("inj_code", 32'(bus_if.out_code), 32'hAA);
`endif
    dec(8'hAA);
    tick();
    chk("inj_dec", 32'({bus_if.out_code, bus_if.out_single_err, bus_if.out_double_err, bus_if.out_data}), 32'h0B);
    bus_if.inj_en = 1'b0;

    // Reset with a held beat discards it
    bus_if.out_ready = 1'b0;
    enc(4'b0001);
    tick();
    chk("mid_held", 32'(bus_if.out_valid), 32'h1);
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst", 32'({bus_if.out_valid, bus_if.out_code}), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_ready", 32'(bus_if.in_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
